// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the FSM state enum, opcode values, the 3-bit aluop code sent to
// the ALU decoder, and the alusrcb / pcsrc mux select encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REX,
    S_RWB, S_BEQ, S_ADDIEX, S_ORIEX, S_ANDIEX, S_IWB, S_JUMP, S_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_OR    = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_FUNCT = 3'b100;

  localparam logic [1:0] ALUB_REG   = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that sit waiting on mem_ready and are covered by the wait timer.
  function automatic logic is_mem_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle control FSM and the datapath/memory.
// master: control unit (drives selects/enables, reads op/zero/mem_ready).
// slave : datapath side (the reverse).
interface mc_control_fsm_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       extop;
  logic [2:0] aluop;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       instr_done;
  logic       fault;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, extop, aluop, pcsrc, pcen, instr_done, fault
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, extop, aluop, pcsrc, pcen, instr_done, fault
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts cycles spent waiting on mem_ready in a memory state and flags a
// timeout on the TIMEOUT_CYCLES-th consecutive wait cycle.
// Ports: clk, rst_n (async low), waiting (FSM is in a memory-wait state),
//        mem_ready, timeout (FSM must go to fault next cycle).
module mc_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);
  // Width still 1 when the timeout is disabled so the counter stays legal.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  // Leaving a wait state clears the count, so every entry starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!waiting || mem_ready) cnt_d = '0;
    else if (cnt_q != '1)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds the number of earlier wait cycles, so this fires on the
  // TIMEOUT_CYCLES-th one; a late mem_ready on that cycle still wins.
  if (TIMEOUT_CYCLES == 0) begin : g_no_to
    assign timeout = 1'b0;
  end else begin : g_to
    assign timeout = waiting & ~mem_ready & (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main control unit for the MIPS core. Sequences fetch, decode,
// execute, memory and writeback, drives datapath selects and write enables,
// and traps illegal opcodes and memory stalls longer than TIMEOUT_CYCLES.
// Ports: clk, reset_n (async low), bus (mc_control_fsm_if.master: op/zero/
//        mem_ready in; selects, enables, instr_done, fault out).
module mc_control_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mc_control_fsm_if.master      bus
);
  state_t     state_q, state_d;
  logic       timeout;
  logic       pcwrite, branch;
  logic       mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg;
  logic       alusrca, extop, instr_done, fault;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;

  mc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (reset_n),
    .waiting   (is_mem_wait(state_q)),
    .mem_ready (bus.mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = ALUB_REG;
    extop      = 1'b0;
    aluop      = ALUOP_ADD;
    pcsrc      = PC_ALU;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    fault      = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = ALUB_FOUR;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
        if (timeout)            state_d = S_FAULT;
        else if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        alusrcb = ALUB_IMMSH;
        extop   = 1'b1;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_ANDI:      state_d = S_ANDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
        extop   = 1'b1;
        if (bus.op == OP_LW)      state_d = S_MEMRD;
        else if (bus.op == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FAULT;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (timeout)            state_d = S_FAULT;
        else if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = bus.mem_ready;
        if (timeout)            state_d = S_FAULT;
        else if (bus.mem_ready) state_d = S_FETCH;
      end
      S_REX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RWB;
      end
      S_RWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = PC_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
        extop   = 1'b1;
        state_d = S_IWB;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
        aluop   = ALUOP_OR;
        state_d = S_IWB;
      end
      S_ANDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUB_IMM;
        aluop   = ALUOP_AND;
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = PC_JUMP;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: fault = 1'b1;  // terminal until reset
      default: state_d = S_FAULT;
    endcase
  end

  assign bus.mem_req    = mem_req;
  assign bus.memwrite   = memwrite;
  assign bus.iord       = iord;
  assign bus.irwrite    = irwrite;
  assign bus.regwrite   = regwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.extop      = extop;
  assign bus.aluop      = aluop;
  assign bus.pcsrc      = pcsrc;
  assign bus.pcen       = pcwrite | (branch & bus.zero);
  assign bus.instr_done = instr_done;
  assign bus.fault      = fault;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the driver pushes the hand-derived
// expected output vector for each cycle, a negedge monitor pops and compares.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mc_control_fsm_if bus();

  mc_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic       mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen, instr_done, fault;
  } ov_t;

  localparam int T_RESET = 0, T_FETCH = 1, T_DECODE = 2, T_MEMADR = 3, T_MEMRD = 4,
                 T_MEMWB = 5, T_MEMWR = 6, T_REX = 7, T_RWB = 8, T_BEQ = 9,
                 T_ADDI = 10, T_ORI = 11, T_ANDI = 12, T_IWB = 13, T_JUMP = 14,
                 T_FAULT = 15;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, ORI = 6'b001101,
                         ANDI = 6'b001100, JMP = 6'b000010, BAD = 6'b111111;

  ov_t   exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Expected outputs per state, written out from the control table.
  function automatic ov_t ev(int s, logic mr, logic z);
    ov_t o = '0;
    case (s)
      T_FETCH:  begin o.mem_req = 1; o.alusrcb = 2'b01; o.irwrite = mr; o.pcen = mr; end
      T_DECODE: begin o.alusrcb = 2'b11; o.extop = 1; end
      T_MEMADR: begin o.alusrca = 1; o.alusrcb = 2'b10; o.extop = 1; end
      T_MEMRD:  begin o.mem_req = 1; o.iord = 1; end
      T_MEMWB:  begin o.regwrite = 1; o.memtoreg = 1; o.instr_done = 1; end
      T_MEMWR:  begin o.mem_req = 1; o.memwrite = 1; o.iord = 1; o.instr_done = mr; end
      T_REX:    begin o.alusrca = 1; o.aluop = 3'b100; end
      T_RWB:    begin o.regwrite = 1; o.regdst = 1; o.instr_done = 1; end
      T_BEQ:    begin o.alusrca = 1; o.aluop = 3'b001; o.pcsrc = 2'b01; o.pcen = z; o.instr_done = 1; end
      T_ADDI:   begin o.alusrca = 1; o.alusrcb = 2'b10; o.extop = 1; end
      T_ORI:    begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluop = 3'b010; end
      T_ANDI:   begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluop = 3'b011; end
      T_IWB:    begin o.regwrite = 1; o.instr_done = 1; end
      T_JUMP:   begin o.pcsrc = 2'b10; o.pcen = 1; o.instr_done = 1; end
      T_FAULT:  o.fault = 1;
      default:  o = '0;
    endcase
    return o;
  endfunction

  function automatic ov_t actual();
    ov_t a;
    a.mem_req = bus.mem_req;   a.memwrite = bus.memwrite; a.iord = bus.iord;
    a.irwrite = bus.irwrite;   a.regwrite = bus.regwrite; a.regdst = bus.regdst;
    a.memtoreg = bus.memtoreg; a.alusrca = bus.alusrca;   a.alusrcb = bus.alusrcb;
    a.extop = bus.extop;       a.aluop = bus.aluop;       a.pcsrc = bus.pcsrc;
    a.pcen = bus.pcen;         a.instr_done = bus.instr_done; a.fault = bus.fault;
    return a;
  endfunction

  // One clock: drive inputs just after the edge, queue the expected outputs.
  task automatic cyc(string tag, int s, logic [5:0] o, logic mr, logic z, logic rn);
    @(posedge clk);
    #1;
    reset_n       = rn;
    bus.op        = o;
    bus.mem_ready = mr;
    bus.zero      = z;
    exp_q.push_back(ev(s, mr, z));
    tag_q.push_back(tag);
  endtask

  task automatic instr4(string tag, logic [5:0] o, int ex, int wb);
    cyc({tag, "_fetch"}, T_FETCH, o, 1, 0, 1);
    cyc({tag, "_decode"}, T_DECODE, o, 1, 0, 1);
    cyc({tag, "_ex"}, ex, o, 1, 0, 1);
    cyc({tag, "_wb"}, wb, o, 1, 0, 1);
  endtask

  ov_t   mon_e, mon_a;
  string mon_t;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = actual();
      n_checks++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", mon_t, mon_a, mon_e);
      end
    end
  end

  initial begin
    reset_n = 1'b0; bus.op = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
    cyc("reset0", T_RESET, RT, 0, 0, 0);
    cyc("reset1", T_RESET, RT, 1, 0, 0);
    cyc("release", T_RESET, RT, 1, 0, 1);

    // lw, memory always ready
    cyc("lw_fetch", T_FETCH, LW, 1, 0, 1);
    cyc("lw_decode", T_DECODE, LW, 1, 0, 1);
    cyc("lw_memadr", T_MEMADR, LW, 1, 0, 1);
    cyc("lw_memrd", T_MEMRD, LW, 1, 0, 1);
    cyc("lw_memwb", T_MEMWB, LW, 1, 0, 1);

    instr4("rtype", RT, T_REX, T_RWB);

    cyc("beq1_fetch", T_FETCH, BEQ, 1, 0, 1);
    cyc("beq1_decode", T_DECODE, BEQ, 1, 0, 1);
    cyc("beq1_taken", T_BEQ, BEQ, 1, 1, 1);
    cyc("beq0_fetch", T_FETCH, BEQ, 1, 0, 1);
    cyc("beq0_decode", T_DECODE, BEQ, 1, 0, 1);
    cyc("beq0_nottaken", T_BEQ, BEQ, 1, 0, 1);

    instr4("ori", ORI, T_ORI, T_IWB);
    instr4("andi", ANDI, T_ANDI, T_IWB);
    instr4("addi", ADDI, T_ADDI, T_IWB);

    cyc("j_fetch", T_FETCH, JMP, 1, 0, 1);
    cyc("j_decode", T_DECODE, JMP, 1, 0, 1);
    cyc("j_jump", T_JUMP, JMP, 1, 0, 1);

    // fetch stalls 3 cycles, ready on the 4th: no fault
    for (int i = 0; i < 3; i++) cyc("fetch_wait", T_FETCH, ADDI, 0, 0, 1);
    cyc("fetch_ready", T_FETCH, ADDI, 1, 0, 1);
    cyc("fw_decode", T_DECODE, ADDI, 1, 0, 1);
    cyc("fw_ex", T_ADDI, ADDI, 1, 0, 1);
    cyc("fw_wb", T_IWB, ADDI, 1, 0, 1);

    // sw ready exactly on the timeout cycle: normal completion
    cyc("sw_fetch", T_FETCH, SW, 1, 0, 1);
    cyc("sw_decode", T_DECODE, SW, 1, 0, 1);
    cyc("sw_memadr", T_MEMADR, SW, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc("sw_wait", T_MEMWR, SW, 0, 0, 1);
    cyc("sw_ready_at_limit", T_MEMWR, SW, 1, 0, 1);

    // sw stuck: fault after 4 wait cycles, sticky
    cyc("swto_fetch", T_FETCH, SW, 1, 0, 1);
    cyc("swto_decode", T_DECODE, SW, 1, 0, 1);
    cyc("swto_memadr", T_MEMADR, SW, 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc("swto_wait", T_MEMWR, SW, 0, 0, 1);
    cyc("swto_fault", T_FAULT, SW, 0, 0, 1);
    cyc("swto_sticky", T_FAULT, SW, 1, 1, 1);
    cyc("swto_rst", T_RESET, SW, 1, 0, 0);
    cyc("swto_rel", T_RESET, SW, 1, 0, 1);

    // illegal opcode
    cyc("bad_fetch", T_FETCH, BAD, 1, 0, 1);
    cyc("bad_decode", T_DECODE, BAD, 1, 0, 1);
    cyc("bad_fault", T_FAULT, BAD, 1, 0, 1);
    cyc("bad_sticky", T_FAULT, RT, 1, 0, 1);
    cyc("bad_rst", T_RESET, RT, 1, 0, 0);
    cyc("bad_rel", T_RESET, RT, 1, 0, 1);

    // async reset in the middle of S_REX
    cyc("rx_fetch", T_FETCH, RT, 1, 0, 1);
    cyc("rx_decode", T_DECODE, RT, 1, 0, 1);
    cyc("rx_rex", T_REX, RT, 1, 0, 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (actual() !== ev(T_RESET, 0, 0)) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", actual(), ev(T_RESET, 0, 0));
    end
    cyc("rx_held", T_RESET, RT, 1, 0, 0);
    cyc("rx_rel", T_RESET, RT, 1, 0, 1);
    cyc("rx_refetch", T_FETCH, RT, 1, 0, 1);
    cyc("rx_redecode", T_DECODE, RT, 1, 0, 1);

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
